// File: rtl/phase_ctrl.sv
// Five-phase instruction sequencer (fetch, read, execute, memory, writeback) with
// idle/halt states, per-phase strobes and a wrapping retired-instruction counter.
module phase_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             stop,
   input  logic             mem_wait,
   input  logic             halt_req,
   input  logic             mem_op,
   input  logic             mem_wr,
   input  logic             wb_en,
   output logic [2:0]       phase,
   output logic [4:0]       ph_onehot,
   output logic             ir_we,
   output logic             pc_we,
   output logic             rf_we,
   output logic             mem_re,
   output logic             dmem_we,
   output logic             busy,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   // Active phases share their encoding with the phase output value.
   typedef enum logic [2:0] {
      S_F    = 3'd0,
      S_R    = 3'd1,
      S_X    = 3'd2,
      S_M    = 3'd3,
      S_W    = 3'd4,
      S_IDLE = 3'd5,
      S_HALT = 3'd6
   } state_t;

   state_t state, next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         instr_count <= '0;
      end else begin
         state <= next;
         if (state == S_W)
            instr_count <= instr_count + 1'b1;
      end
   end

   always_comb begin
      next    = state;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      rf_we   = 1'b0;
      mem_re  = 1'b0;
      dmem_we = 1'b0;
      case (state)
         S_IDLE: if (run) next = S_F;
         S_F: begin
            mem_re = 1'b1;
            if (!mem_wait) begin
               ir_we = 1'b1;
               next  = S_R;
            end
         end
         S_R:    next = halt_req ? S_HALT : S_X;
         S_X:    next = mem_op ? S_M : S_W;
         S_M: begin
            if (mem_wr) dmem_we = !mem_wait;
            else        mem_re  = 1'b1;
            if (!mem_wait) next = S_W;
         end
         S_W: begin
            pc_we = 1'b1;
            rf_we = wb_en;
            next  = stop ? S_IDLE : S_F;
         end
         S_HALT: next = S_HALT;
         default: next = S_IDLE;
      endcase
      // Strobes are suppressed while reset is held, whatever state we came from.
      if (rst) begin
         ir_we   = 1'b0;
         pc_we   = 1'b0;
         rf_we   = 1'b0;
         mem_re  = 1'b0;
         dmem_we = 1'b0;
      end
   end

   always_comb begin
      phase     = 3'd7;
      ph_onehot = 5'b00000;
      busy      = 1'b0;
      halted    = 1'b0;
      case (state)
         S_F: begin phase = 3'd0; ph_onehot = 5'b00001; busy = 1'b1; end
         S_R: begin phase = 3'd1; ph_onehot = 5'b00010; busy = 1'b1; end
         S_X: begin phase = 3'd2; ph_onehot = 5'b00100; busy = 1'b1; end
         S_M: begin phase = 3'd3; ph_onehot = 5'b01000; busy = 1'b1; end
         S_W: begin phase = 3'd4; ph_onehot = 5'b10000; busy = 1'b1; end
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/phase_ctrl.md
PHASE_CTRL -- requirements
Module: phase_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of retired-instruction counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 run  in  1  start request; sampled only in IDLE.
REQ-005 stop  in  1  return to IDLE after current instruction; sampled only in W.
REQ-006 mem_wait  in  1  memory not ready; stalls F and M.
REQ-007 halt_req  in  1  decoded HLT instruction; sampled only in R.
REQ-008 mem_op  in  1  current instruction accesses data memory; sampled only in X.
REQ-009 mem_wr  in  1  data access is a store (1) or load (0); used only in M.
REQ-010 wb_en  in  1  current instruction writes register file; used only in W.
REQ-011 phase  out  3  0=F,1=R,2=X,3=M,4=W, 7=IDLE or HALT.
REQ-012 ph_onehot  out  5  bit n set iff phase==n; 0 in IDLE/HALT.
REQ-013 ir_we  out  1  instruction register load strobe.
REQ-014 pc_we  out  1  program counter update strobe.
REQ-015 rf_we  out  1  register file write strobe.
REQ-016 mem_re  out  1  memory read enable.
REQ-017 dmem_we  out  1  data memory write strobe.
REQ-018 busy  out  1  high in F,R,X,M,W.
REQ-019 halted  out  1  high in HALT.
REQ-020 instr_count  out  CNT_W  count of retired instructions.

Function
REQ-021 States: IDLE, F, R, X, M, W, HALT; exactly one active; phase/ph_onehot/busy/halted are decoded from state only (Moore).
REQ-022 IDLE: run=1 -> F next cycle; else remain.
REQ-023 F: mem_re=1; mem_wait=1 -> stay in F, ir_we=0; mem_wait=0 -> ir_we=1 same cycle, next R.
REQ-024 R: halt_req=1 -> HALT; else X; one cycle, no strobes.
REQ-025 X: mem_op=1 -> M; mem_op=0 -> W (M skipped); one cycle, no strobes.
REQ-026 M: mem_wr=0 -> mem_re=1; mem_wr=1 -> dmem_we=mem_wait?0:1; mem_wait=1 -> stay in M; mem_wait=0 -> next W.
REQ-027 M load with mem_wait=1: mem_re held high every stall cycle.
REQ-028 W: pc_we=1, rf_we=wb_en, instr_count+1 at edge; stop=1 -> IDLE, else F; always exactly one cycle.
REQ-029 HALT: absorbing; run, stop, mem_wait ignored; all strobes 0; exit only via rst.
REQ-030 Strobes ir_we, pc_we, rf_we, dmem_we are each high at most one cycle per instruction; never high outside their stated state.
REQ-031 instr_count wraps from 2^CNT_W-1 to 0 with no flag; increments only on W exit.
REQ-032 Inputs outside their sampling state have no effect; halt_req in R takes priority—no pc_we for halted instruction.
REQ-033 Minimum latency F->F: 4 cycles (no mem_op, no wait); 5 cycles with mem_op.

Reset
REQ-034 rst=1 at an edge -> state IDLE, instr_count=0 next cycle, regardless of current state, including HALT and mid-stall.
REQ-035 During and after reset until run: phase=7, ph_onehot=0, all strobes 0, busy=0, halted=0.
REQ-036 rst has priority over run in the same cycle.

Verification
REQ-037 rst, then run=1 one cycle, mem_op=0, mem_wait=0, wb_en=1 -> phase 0,1,2,4,0 repeating; ir_we in F, pc_we+rf_we in W; instr_count=3 after 3 W cycles.
REQ-038 mem_op=1, mem_wr=1, mem_wait high 2 cycles in M -> M lasts 3 cycles, dmem_we=1 only in third M cycle, then W.
REQ-039 mem_wait=1 for 3 cycles in F -> phase=0 for 4 cycles, mem_re=1 throughout, ir_we=1 only in 4th cycle.
REQ-040 halt_req=1 in R -> HALT next cycle, phase=7, halted=1, no pc_we; run=1 and stop=1 ignored for 10 cycles; rst -> IDLE, halted=0.
REQ-041 stop=1 in W -> IDLE next cycle, busy=0; run=1 -> F following cycle; instr_count preserved.
REQ-042 CNT_W=4, run 16 instructions -> instr_count wraps 15->0; rst asserted in M stall -> IDLE, instr_count=0, no strobes.
